user_core_nmi_arbiter: RTL

Parametrised N-to-1 arbiter for the native memory interface (NMI: valid/ready/addr/wdata/wstrb/rdata). It lets up to `NUM_MST` user cores, or a core plus accelerator/DMA masters, share the single `nmi` master port that `user_core_design` drives toward the SoC crossbar. Arbitration is round-robin, and a grant is held for exactly one transaction. An optional watchdog terminates transactions the downstream never acknowledges.

---
 rtl/user_core_nmi_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/user_core_nmi_arbiter.sv
// Round-robin N-to-1 arbiter for the native memory interface; one transaction per grant.
// Optional watchdog enabled by defining NMI_ARB_TIMEOUT_EN.
module user_core_nmi_arbiter #(
  parameter logic [4:0] ID          = 5'd31,
  parameter int         NUM_MST     = 2,
  parameter int         ADDR_WIDTH  = 32,
  parameter int         DATA_WIDTH  = 32,
  parameter int         TIMEOUT_CYC = 1024,
  localparam int        IW          = $clog2(NUM_MST),
  localparam int        SW          = DATA_WIDTH / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_MST-1:0]            s_valid_i,
  input  logic [NUM_MST*ADDR_WIDTH-1:0] s_addr_i,
  input  logic [NUM_MST*DATA_WIDTH-1:0] s_wdata_i,
  input  logic [NUM_MST*SW-1:0]         s_wstrb_i,
  output logic [NUM_MST-1:0]            s_ready_o,
  output logic [DATA_WIDTH-1:0]         s_rdata_o,
  output logic                          m_valid_o,
  output logic [ADDR_WIDTH-1:0]         m_addr_o,
  output logic [DATA_WIDTH-1:0]         m_wdata_o,
  output logic [SW-1:0]                 m_wstrb_o,
  input  logic                          m_ready_i,
  input  logic [DATA_WIDTH-1:0]         m_rdata_i,
  output logic                          busy_o,
  output logic [IW-1:0]                 gnt_o,
  output logic                          err_o,
  output logic [IW-1:0]                 err_mst_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   gnt, gnt_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic            busy;
  logic            req;
  logic            done;
  logic            expire;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [SW-1:0]         sel_wstrb;

  // First requester at or after base, wrapping modulo NUM_MST.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_MST-1:0] reqs,
                                            input logic [IW-1:0]      base);
    logic [IW-1:0] pick;
    int            idx;
    pick = '0;
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      idx = int'(base) + i;
      if (idx >= NUM_MST) idx = idx - NUM_MST;
      if (reqs[idx]) pick = IW'(idx);
    end
    return pick;
  endfunction

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] cur);
    logic [IW-1:0] nxt;
    if (cur == IW'(NUM_MST - 1)) nxt = '0;
    else                         nxt = cur + 1'b1;
    return nxt;
  endfunction

  assign busy = (state == BUSY);

  always_comb begin
    req       = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      if (gnt == IW'(k)) begin
        req       = s_valid_i[k];
        sel_addr  = s_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = s_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        sel_wstrb = s_wstrb_i[k*SW +: SW];
      end
    end
  end

  // A master that withdraws valid mid-transaction never completes, even if ready coincides.
  assign done = busy && req && m_ready_i;

`ifdef NMI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;

  logic [CW-1:0] cnt;
  logic [IW-1:0] err_mst;

  // 32'hDEAD_BEEF replicated or truncated to the data width.
  function automatic logic [DATA_WIDTH-1:0] dead_word();
    logic [31:0]           pat;
    logic [DATA_WIDTH-1:0] w;
    pat = 32'hDEAD_BEEF;
    for (int i = 0; i < DATA_WIDTH; i++) w[i] = pat[i % 32];
    return w;
  endfunction

  // cnt holds the number of earlier stalled BUSY cycles, so expiry is the TIMEOUT_CYC-th one.
  assign expire = busy && req && !m_ready_i && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt     <= '0;
      err_mst <= '0;
    end else begin
      if (!busy)                        cnt <= '0;
      else if (!m_ready_i && cnt != '1) cnt <= cnt + 1'b1;
      if (expire) err_mst <= gnt;
    end
  end

  assign err_mst_o = err_mst;
  assign s_rdata_o = done ? m_rdata_i : (expire ? dead_word() : '0);
`else
  assign expire    = 1'b0;
  assign err_mst_o = '0;
  assign s_rdata_o = done ? m_rdata_i : '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (|s_valid_i) begin
          gnt_nxt   = rr_pick(s_valid_i, ptr);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (done || expire) begin
          ptr_nxt   = wrap_inc(gnt);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready_o = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      if (gnt == IW'(k)) s_ready_o[k] = done || expire;
    end
  end

  assign m_valid_o = busy && req && !expire;
  assign m_addr_o  = busy ? sel_addr  : '0;
  assign m_wdata_o = busy ? sel_wdata : '0;
  assign m_wstrb_o = busy ? sel_wstrb : '0;
  assign busy_o    = busy;
  assign gnt_o     = gnt;
  assign err_o     = expire;

endmodule
